// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: IDLE -> BUSY -> RELEASE -> IDLE, one owner at a time.
// Define BUS_ARB_TIMEOUT_EN to force release of an owner after TIMEOUT_CYCLES busy cycles.
module bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ID_W           = $clog2(NUM_MASTERS),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] m_req,
  input  logic [NUM_MASTERS-1:0] m_done,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [ID_W-1:0]        grant_id,
  output logic                   bus_busy,
  output logic                   timeout_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY    = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_MASTERS - 1);

  if (NUM_MASTERS < 2 || TIMEOUT_CYCLES < 2) begin : g_cfg_err
    $error("bus_arbiter: NUM_MASTERS and TIMEOUT_CYCLES must be >= 2");
  end

  logic [1:0]             state;
  logic [ID_W-1:0]        rr_ptr;
  logic                   pick_vld;
  logic [ID_W-1:0]        pick_id;
  logic [ID_W-1:0]        scan_id;
  logic [NUM_MASTERS-1:0] pick_oh;
  logic                   owner_rel;
  logic                   force_rel;

  // Search upward from the last winner, wrapping, so the last winner is checked last.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    scan_id  = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      scan_id = ID_W'((int'(rr_ptr) + i) % NUM_MASTERS);
      if (!pick_vld && m_req[scan_id]) begin
        pick_vld = 1'b1;
        pick_id  = scan_id;
      end
    end
  end

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_oh
    assign pick_oh[g] = (pick_id == ID_W'(g));
  end

  assign owner_rel = m_done[grant_id] | ~m_req[grant_id];

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] to_cnt;
  logic             to_hit;

  assign to_hit    = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign force_rel = owner_rel | to_hit;

  // Counter sits at zero outside BUSY, so every burst starts counting from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      to_cnt      <= (state == BUSY) ? to_cnt + 1'b1 : '0;
      timeout_err <= (state == BUSY) && to_hit && !owner_rel;
    end
  end
`else
  assign force_rel   = owner_rel;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= PTR_RST;
      grant    <= '0;
      grant_id <= '0;
      bus_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant    <= pick_oh;
            grant_id <= pick_id;
            bus_busy <= 1'b1;
            rr_ptr   <= pick_id;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (force_rel) begin
            grant    <= '0;
            bus_busy <= 1'b0;
            state    <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: begin
          grant    <= '0;
          bus_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: scenario tasks checked every cycle against a rule-level arbiter model.
// Timeout scenarios run only when BUS_ARB_TIMEOUT_EN is defined.
module tb_bus_arbiter;

  localparam int NM     = 3;
  localparam int IW     = 2;
  localparam int TO_CYC = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NM-1:0] m_req = '0;
  logic [NM-1:0] m_done = '0;
  logic [NM-1:0] grant;
  logic [IW-1:0] grant_id;
  logic          bus_busy;
  logic          timeout_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: current owner (-1 none), turnaround pending, last winner, busy cycles so far.
  int            own, gap, last, busy_n;
  logic [NM-1:0] exp_grant;
  logic          exp_terr;

  bus_arbiter #(.NUM_MASTERS(NM), .ID_W(IW), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_done(m_done),
    .grant(grant), .grant_id(grant_id), .bus_busy(bus_busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    own = -1; gap = 0; last = NM - 1; busy_n = 0;
    exp_grant = '0; exp_terr = 1'b0;
  endtask

  task automatic model_step();
    bit rel, to;
    exp_terr = 1'b0;
    if (own >= 0) begin
      rel = m_done[own] || !m_req[own];
      to  = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      to  = (busy_n == TO_CYC);
`endif
      if (rel || to) begin
        exp_terr = !rel;
        own = -1;
        gap = 1;
      end else busy_n++;
    end else if (gap != 0) begin
      gap = 0;
    end else begin
      for (int i = 1; i <= NM; i++) begin
        int w;
        w = (last + i) % NM;
        if (own < 0 && m_req[w]) begin
          own = w; last = w; busy_n = 1;
        end
      end
    end
    exp_grant = '0;
    if (own >= 0) exp_grant[own] = 1'b1;
  endtask

  // Called at a falling edge; returns at the next falling edge with the model updated.
  task automatic tick(input logic [NM-1:0] req, input logic [NM-1:0] done);
    m_req = req; m_done = done;
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; m_req = '0; m_done = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({grant, grant_id, bus_busy, timeout_err} !== '0) begin
      failures++;
      $display("FAIL reset_values grant=%b id=%0d busy=%b terr=%b required all zero",
               grant, grant_id, bus_busy, timeout_err);
    end
    repeat (3) begin
      tick('0, '0);
      checks++;
      if (grant !== '0 || bus_busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d grant=%b busy=%b required 0 0", cyc, grant, bus_busy);
      end
    end
  endtask

  task automatic test_single_burst();
    int high = 0;
    for (int n = 0; n < 16; n++) begin
      tick(3'b001, (own >= 0 && busy_n == 10) ? exp_grant : '0);
      if (grant !== '0) high++;
      checks++;
      if (grant !== exp_grant || bus_busy !== (own >= 0) || timeout_err !== exp_terr ||
          (own >= 0 && grant_id !== IW'(own))) begin
        failures++;
        $display("FAIL single_burst cyc=%0d grant=%b id=%0d busy=%b terr=%b required grant=%b busy=%b terr=%b",
                 cyc, grant, grant_id, bus_busy, timeout_err, exp_grant, own >= 0, exp_terr);
      end
    end
    checks++;
    if (high < 10) begin
      failures++;
      $display("FAIL single_burst_len first burst cycles=%0d required at least 10", high);
    end
    repeat (3) tick('0, '0);
  endtask

  task automatic test_alternate();
    int zero_run = 0, prev = -1, grants = 0;
    for (int n = 0; n < 60; n++) begin
      tick(3'b011, (own >= 0 && busy_n == 8) ? exp_grant : '0);
      checks++;
      if (grant !== exp_grant || bus_busy !== (own >= 0) ||
          (own >= 0 && grant_id !== IW'(own))) begin
        failures++;
        $display("FAIL alternate cyc=%0d grant=%b id=%0d busy=%b required grant=%b busy=%b",
                 cyc, grant, grant_id, bus_busy, exp_grant, own >= 0);
      end
      if (grant === '0) zero_run++;
      else if (zero_run != 0) begin
        if (grants > 0) begin
          checks++;
          if (zero_run != 2 || int'(grant_id) == prev) begin
            failures++;
            $display("FAIL alternate_gap cyc=%0d gap=%0d owner=%0d prev=%0d required gap 2 and new owner",
                     cyc, zero_run, grant_id, prev);
          end
        end
        prev = int'(grant_id);
        grants++;
        zero_run = 0;
      end
    end
    repeat (3) tick('0, '0);
  endtask

  task automatic test_withdraw();
    repeat (3) tick('0, '0);
    for (int n = 0; n < 9; n++) begin
      if (n == 5) tick(3'b000, 3'b010);
      else if (n < 5) tick(3'b001, '0);
      else tick('0, '0);
      checks++;
      if (grant !== exp_grant || bus_busy !== (own >= 0)) begin
        failures++;
        $display("FAIL withdraw cyc=%0d grant=%b busy=%b required grant=%b busy=%b",
                 cyc, grant, bus_busy, exp_grant, own >= 0);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    repeat (4) tick(3'b010, '0);
    checks++;
    if (grant !== 3'b010) begin
      failures++;
      $display("FAIL reset_mid_setup grant=%b required 010", grant);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== '0 || bus_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_async grant=%b busy=%b required 000 0", grant, bus_busy);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick(3'b011, '0);
    checks++;
    if (grant !== 3'b001 || grant !== exp_grant) begin
      failures++;
      $display("FAIL reset_mid_first grant=%b required 001", grant);
    end
    repeat (3) tick('0, '0);
  endtask

  task automatic test_random();
    logic [NM-1:0] r, d;
    r = '0;
    for (int n = 0; n < 400; n++) begin
      d = '0;
      for (int m = 0; m < NM; m++) begin
        if (m == own) begin
          if ($urandom_range(0, 19) == 0) r[m] = 1'b0;
          else if ($urandom_range(0, 5) == 0) d[m] = 1'b1;
        end else begin
          if (!r[m] && $urandom_range(0, 3) == 0) r[m] = 1'b1;
          if ($urandom_range(0, 7) == 0) d[m] = 1'b1;
        end
      end
      tick(r, d);
      checks++;
      if (grant !== exp_grant || bus_busy !== (own >= 0) || timeout_err !== exp_terr ||
          (own >= 0 && grant_id !== IW'(own))) begin
        failures++;
        $display("FAIL random cyc=%0d req=%b done=%b grant=%b id=%0d busy=%b terr=%b required grant=%b busy=%b terr=%b",
                 cyc, r, d, grant, grant_id, bus_busy, timeout_err, exp_grant, own >= 0, exp_terr);
      end
    end
    repeat (3) tick('0, '0);
  endtask

`ifdef BUS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int pulses = 0;
    apply_reset();
    for (int n = 0; n < 45; n++) begin
      tick(3'b001, '0);
      if (timeout_err === 1'b1) pulses++;
      checks++;
      if (grant !== exp_grant || bus_busy !== (own >= 0) || timeout_err !== exp_terr) begin
        failures++;
        $display("FAIL timeout cyc=%0d grant=%b busy=%b terr=%b required grant=%b busy=%b terr=%b",
                 cyc, grant, bus_busy, timeout_err, exp_grant, own >= 0, exp_terr);
      end
    end
    checks++;
    if (pulses != 2) begin
      failures++;
      $display("FAIL timeout_pulses count=%0d required 2", pulses);
    end
    repeat (3) tick('0, '0);
  endtask

  task automatic test_timeout_precedence();
    int burst = 0;
    apply_reset();
    for (int n = 0; n < 44; n++) begin
      if (own >= 0 && busy_n == ((burst == 0) ? TO_CYC - 1 : TO_CYC)) begin
        tick(3'b001, 3'b001);
        burst++;
      end else tick(3'b001, '0);
      checks++;
      if (grant !== exp_grant || timeout_err !== 1'b0 || exp_terr !== 1'b0) begin
        failures++;
        $display("FAIL timeout_precedence cyc=%0d grant=%b terr=%b required grant=%b terr=0",
                 cyc, grant, timeout_err, exp_grant);
      end
    end
    repeat (3) tick('0, '0);
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_single_burst();
    test_alternate();
    test_withdraw();
    test_reset_mid_burst();
    test_random();
`ifdef BUS_ARB_TIMEOUT_EN
    test_timeout();
    test_timeout_precedence();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
